// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - buffers consumer result words and streams them out LSB byte first
module result_serializer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] result,
  input  logic              result_valid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int NBYTES = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [IDX_W-1:0]  idx;
  logic              ovf_q;
  logic [7:0]        head_byte;
  logic              handshake;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    head_byte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (idx == IDX_W'(b)) head_byte = mem[rd_ptr][8*b +: 8];
    end
  end

  assign out_valid = (count != '0);
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign out_data  = out_valid ? head_byte : 8'h00;
  assign level     = count;
  assign overflow  = ovf_q;

  // A head word completing this cycle frees its slot, so a full FIFO can still accept.
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && out_last;
  assign push      = result_valid && ((count != FULL) || pop);
  assign drop      = result_valid && (count == FULL) && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase

      if (handshake) idx <= out_last ? '0 : idx + IDX_W'(1);

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)                ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - scoreboard bench for result_serializer with a word-level reference model
module tb_result_serializer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int NBYTES = DATA_W / 8;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] result = '0;
  logic              result_valid = 1'b0;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              clear_overflow = 1'b0;

  result_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .level(level), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: words held (incl. partial head), bytes already sent from head, flag.
  int         m_words = 0;
  int         m_sent  = 0;
  bit         m_ovf   = 1'b0;
  logic [8:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_words = 0;
    m_sent  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit hs, completes, full;
    if (rst) begin
      model_clear();
      return;
    end
    hs        = out_ready && (m_words > 0);
    completes = hs && (m_sent == NBYTES - 1);
    full      = (m_words == DEPTH);
    if (hs) begin
      if (completes) begin
        m_words--;
        m_sent = 0;
      end else begin
        m_sent++;
      end
    end
    if (result_valid && (!full || completes)) begin
      m_words++;
      for (int b = 0; b < NBYTES; b++) sb.push_back({b == NBYTES - 1, result[8*b +: 8]});
    end
    if (result_valid && full && !completes) m_ovf = 1'b1;
    else if (clear_overflow)                m_ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drive(input bit rv, input logic [DATA_W-1:0] r, input bit rdy, input bit clr);
    result_valid   = rv;
    result         = r;
    out_ready      = rdy;
    clear_overflow = clr;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    model_clear();
    result_valid   = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compares state every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      chk("level", level, m_words);
      chk("out_valid", out_valid, m_words != 0);
      chk("overflow", overflow, m_ovf);
      if (!out_valid) begin
        chk("idle_out_data", out_data, 0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL sb_empty: got byte 0x%0h expected no byte at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e[7:0]);
          chk("out_last", out_last, e[8]);
        end
      end
    end
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Single word streamed with out_ready high
    drive(1, 16'hBEEF, 1, 0);
    chk("t2_byte0", out_data, 8'hEF);
    chk("t2_last0", out_last, 0);
    chk("t2_level", level, 1);
    drive(0, 0, 1, 0);
    chk("t2_byte1", out_data, 8'hBE);
    chk("t2_last1", out_last, 1);
    drive(0, 0, 1, 0);
    chk("t2_empty", out_valid, 0);

    // Backpressure holds the head byte
    drive(1, 16'h1234, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", out_data, 8'h34);
      chk("t3_hold_valid", out_valid, 1);
      drive(0, 0, 0, 0);
    end
    drive(0, 0, 1, 0);
    chk("t3_byte1", out_data, 8'h12);
    chk("t3_last", out_last, 1);
    drive(0, 0, 1, 0);

    // Reset asserted mid-cycle with data stored
    drive(1, 16'h5555, 0, 0);
    do_reset();

    // Overflow on full FIFO
    for (int i = 1; i <= 4; i++) drive(1, 16'(i), 0, 0);
    chk("t4_full", level, 4);
    drive(1, 16'h0005, 0, 0);
    chk("t4_level", level, 4);
    chk("t4_ovf", overflow, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0);
    chk("t4_drained", level, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // Full FIFO accepts when the head completes in the same cycle
    drive(0, 0, 0, 1);
    chk("t5_clr", overflow, 0);
    for (int i = 1; i <= 4; i++) drive(1, 16'(i * 16'h1111), 0, 0);
    drive(0, 0, 1, 0);
    chk("t5_head_last", out_last, 1);
    drive(1, 16'hAAAA, 1, 0);
    chk("t5_level", level, 4);
    chk("t5_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0);
    chk("t5_drained", level, 0);

    // Set beats clear; reset mid-word
    for (int i = 1; i <= 4; i++) drive(1, 16'(i), 0, 0);
    drive(1, 16'h9999, 0, 1);
    chk("t6_set_wins", overflow, 1);
    drive(0, 0, 0, 1);
    chk("t6_cleared", overflow, 0);
    do_reset();
    for (int i = 1; i <= 3; i++) drive(1, 16'(i * 16'h0101), 0, 0);
    drive(0, 0, 1, 0);
    chk("t6_midword", level, 3);
    do_reset();
    drive(1, 16'h00FF, 0, 0);
    chk("t6_first", out_data, 8'hFF);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // Randomized traffic with varying backpressure and rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 6, 16'($urandom),
              ((i / 500) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1),
              $urandom_range(0, 19) == 0);
      end
    end
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);
    chk("final_level", level, 0);
    chk("final_sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Downstream neighbour of the consumer stage in the pipeline.
- Captures each DATA_W-bit result the consumer emits, buffers it in a small FIFO, and streams it out byte-by-byte, LSB byte first, over a valid/ready interface.
- Absorbs consumer results, which arrive with no backpressure, and reports drops via a sticky overflow flag.

Parameters:
- DATA_W, 16, result word width; must be a multiple of 8 and at least 8. NBYTES = DATA_W/8.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.
- LVL_W, $clog2(DEPTH+1), width of the level output (derived; do not override).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- result  input  DATA_W  result word from the consumer.
- result_valid  input  1  result qualifier; one word per cycle when high; no backpressure.
- out_data  output  8  current output byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte; handshake = out_valid && out_ready.
- out_last  output  1  out_data is the final (MSB) byte of its word.
- level  output  LVL_W  words held, including a partially sent head word.
- overflow  output  1  sticky: a result was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync deassert usage):
  - level=0, out_valid=0, out_last=0, out_data=0, overflow=0.
  - Byte index=0; FIFO pointers=0.
  - Assertion mid-stream discards all stored words and any partially sent word immediately.
- Storage:
  - DEPTH-entry register FIFO with wrapping read/write pointers and a registered word count, which drives level.
- Write:
  - Accept when result_valid && (level<DEPTH || pop_this_cycle).
  - pop_this_cycle = handshake && out_last.
  - A full FIFO whose head is completing on the same cycle therefore still accepts; level stays DEPTH.
- Drop:
  - result_valid && level==DEPTH && !pop_this_cycle: word discarded, overflow<=1, no state change.
- Clear:
  - clear_overflow clears overflow next cycle.
  - If a drop occurs the same cycle, set wins (overflow stays 1).
- Latency:
  - A word written in cycle N into an empty FIFO gives out_valid=1 in cycle N+1.
  - No combinational path from result/result_valid to any output.
- Output path:
  - out_valid = (level!=0).
  - out_data = head[8*idx+7 : 8*idx], where idx is a byte index in 0..NBYTES-1.
  - out_last = out_valid && (idx==NBYTES-1).
  - out_data and out_last are driven from registers/storage (no combinational dependence on out_ready). While out_valid && !out_ready they hold stable.
  - out_data is 0 when out_valid=0.
- Handshake:
  - With !out_last: idx<=idx+1.
  - With out_last: idx<=0, head popped, read pointer wraps modulo DEPTH.
  - Simultaneous pop and write: level unchanged.
- out_ready is ignored when out_valid=0.
- Pointers and count are never corrupted by a drop. level never exceeds DEPTH.
- Invariant: level==0 implies idx==0.

Test Plan:
1. Reset: assert rst mid-cycle -> immediately out_valid=0, level=0, overflow=0, out_data=0x00.
2. Single word, out_ready=1: result=0xBEEF at cycle N -> N+1 out_data=0xEF, out_last=0, level=1; N+2 out_data=0xBE, out_last=1; N+3 out_valid=0, level=0.
3. Backpressure: word 0x1234, out_ready=0 for 5 cycles -> out_data held at 0x34 with out_valid=1 throughout. Then out_ready=1 -> 0x34, 0x12 (last).
4. Overflow: out_ready=0, write 0x0001..0x0004 -> level=4. Write 0x0005 -> dropped, overflow=1, level=4. Drain -> bytes 01,00,02,00,03,00,04,00; 0x05 never appears; overflow stays 1.
5. Full boundary: level=4, head on its last byte, out_ready=1 and result_valid=1 (0xAAAA) same cycle -> accepted, level stays 4, overflow=0. 0xAAAA emerges after the three prior words.
6. Flag priority and reset: clear_overflow=1 coincident with a drop -> overflow=1. clear_overflow alone -> overflow=0 next cycle. Assert rst while level=3 mid-word -> out_valid=0, level=0. After release, new word 0x00FF -> out_data=0xFF first.
